// File: rtl/ariane_sim_ctrl.sv
// Run controller for Ariane simulation/FPGA harnesses: stretched reset, run-cycle
// budget with timeout, divided-down tick channels and first-exit-code capture.
module ariane_sim_ctrl #(
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned NUM_TICK   = 2,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CNT_W-1:0]          max_cycles_i,
  input  logic [NUM_TICK*DIV_W-1:0] div_i,
  input  logic                      exit_valid_i,
  input  logic [31:0]               exit_code_i,
  output logic                      sys_rst_no,
  output logic [NUM_TICK-1:0]       tick_o,
  output logic [NUM_TICK-1:0]       tgl_o,
  output logic [CNT_W-1:0]          cycles_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [31:0]               exit_code_o
);

  localparam logic [1:0] ST_RESET   = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic [1:0]                     state_q, state_d;
  logic [RW-1:0]                  rst_cnt_q, rst_cnt_d;
  logic                           sys_rst_q, sys_rst_d;
  logic [CNT_W-1:0]               cycles_q, cycles_d;
  logic [CNT_W-1:0]               cyc_inc;
  logic                           done_q, done_d;
  logic                           pass_q, pass_d;
  logic                           timeout_q, timeout_d;
  logic [31:0]                    code_q, code_d;
  logic [NUM_TICK-1:0][DIV_W-1:0] tcnt_q, tcnt_d;
  logic [NUM_TICK-1:0]            tick_q, tick_d;
  logic [NUM_TICK-1:0]            tgl_q, tgl_d;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    sys_rst_d = sys_rst_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    code_d    = code_q;
    cyc_inc   = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_RUN;
          sys_rst_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_RUN: begin
        cycles_d = cyc_inc;
        // Exit has priority over a budget expiring on the same cycle.
        if (exit_valid_i) begin
          code_d  = exit_code_i;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((max_cycles_i != '0) && (cyc_inc >= max_cycles_i)) begin
          timeout_d = 1'b1;
          state_d   = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
    pass_d = done_d && (code_d == 32'd1);
  end

  always_comb begin
    logic [DIV_W-1:0] ratio;
    ratio  = '0;
    tcnt_d = tcnt_q;
    tick_d = '0;
    tgl_d  = tgl_q;
    for (int unsigned c = 0; c < NUM_TICK; c++) begin
      ratio = div_i[c*DIV_W +: DIV_W];
      if (state_q != ST_RESET) begin
        // ">=" rather than "==" so a ratio lowered mid-count still wraps promptly.
        if (ratio == '0) begin
          tcnt_d[c] = '0;
        end else if (tcnt_q[c] >= ratio - DIV_W'(1)) begin
          tick_d[c] = 1'b1;
          tcnt_d[c] = '0;
          tgl_d[c]  = ~tgl_q[c];
        end else begin
          tcnt_d[c] = tcnt_q[c] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RESET;
      rst_cnt_q <= '0;
      sys_rst_q <= 1'b0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
      tcnt_q    <= '0;
      tick_q    <= '0;
      tgl_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      sys_rst_q <= sys_rst_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      code_q    <= code_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      tgl_q     <= tgl_d;
    end
  end

  assign sys_rst_no  = sys_rst_q;
  assign tick_o      = tick_q;
  assign tgl_o       = tgl_q;
  assign cycles_o    = cycles_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign exit_code_o = code_q;

endmodule

// File: tb/tb_ariane_sim_ctrl.sv
// Directed bench for ariane_sim_ctrl: reset stretch, exit capture, timeout,
// tick channels, counter saturation and asynchronous mid-run reset.
module tb_ariane_sim_ctrl;

  localparam int unsigned RST = 8;

  logic        clk;
  logic        rst_n;
  logic [63:0] max_cycles;
  logic [31:0] div;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic        sys_rst_n;
  logic [1:0]  tick, tgl;
  logic [63:0] cycles;
  logic        done, pass, timeout;
  logic [31:0] code_out;

  logic        s_sys_rst_n, s_tick, s_tgl, s_done, s_pass, s_timeout;
  logic [3:0]  s_cycles;
  logic [31:0] s_code;

  int checks = 0;
  int errors = 0;

  ariane_sim_ctrl #(
    .RST_CYCLES(RST), .CNT_W(64), .NUM_TICK(2), .DIV_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .max_cycles_i(max_cycles), .div_i(div),
    .exit_valid_i(exit_valid), .exit_code_i(exit_code), .sys_rst_no(sys_rst_n),
    .tick_o(tick), .tgl_o(tgl), .cycles_o(cycles), .done_o(done), .pass_o(pass),
    .timeout_o(timeout), .exit_code_o(code_out)
  );

  ariane_sim_ctrl #(
    .RST_CYCLES(RST), .CNT_W(4), .NUM_TICK(1), .DIV_W(4)
  ) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .max_cycles_i(4'd0), .div_i(4'd0),
    .exit_valid_i(1'b0), .exit_code_i(32'd0), .sys_rst_no(s_sys_rst_n),
    .tick_o(s_tick), .tgl_o(s_tgl), .cycles_o(s_cycles), .done_o(s_done),
    .pass_o(s_pass), .timeout_o(s_timeout), .exit_code_o(s_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(RST);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    max_cycles = '0; div = '0; exit_valid = 1'b0; exit_code = '0;
    step(2);
    checks++;
    if ({sys_rst_n, tick, tgl, cycles, done, pass, timeout, code_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sys_rst_n=%b tick=%b tgl=%b cycles=%0d done=%b pass=%b timeout=%b code=%0h, all required 0",
               sys_rst_n, tick, tgl, cycles, done, pass, timeout, code_out);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= int'(RST); i++) begin
      step();
      checks++;
      if (sys_rst_n !== (i == int'(RST))) begin
        errors++;
        $display("FAIL stretch_edge%0d: sys_rst_n=%b required %b", i, sys_rst_n, (i == int'(RST)));
      end
      checks++;
      if (cycles !== 64'd0) begin
        errors++;
        $display("FAIL stretch_cycles%0d: cycles=%0d required 0", i, cycles);
      end
    end
    step();
    checks++;
    if (cycles !== 64'd1) begin
      errors++;
      $display("FAIL first_run_cycle: cycles=%0d required 1", cycles);
    end
  endtask

  task automatic test_pass_exit();
    do_reset();
    step(99);
    checks++;
    if (cycles !== 64'd99 || done !== 1'b0) begin
      errors++;
      $display("FAIL pre_exit: cycles=%0d done=%b required 99/0", cycles, done);
    end
    exit_valid = 1'b1; exit_code = 32'h1;
    step();
    exit_valid = 1'b0;
    checks++;
    if ({done, pass, timeout} !== 3'b110 || code_out !== 32'h1 || cycles !== 64'd100) begin
      errors++;
      $display("FAIL pass_exit: done=%b pass=%b timeout=%b code=%0h cycles=%0d required 1/1/0/1/100",
               done, pass, timeout, code_out, cycles);
    end
    step(5);
    exit_valid = 1'b1; exit_code = 32'h5;
    step();
    exit_valid = 1'b0;
    step();
    checks++;
    if ({done, pass, timeout, sys_rst_n} !== 4'b1101 || code_out !== 32'h1 || cycles !== 64'd100) begin
      errors++;
      $display("FAIL second_exit_ignored: done=%b pass=%b timeout=%b sys_rst_n=%b code=%0h cycles=%0d required 1/1/0/1/1/100",
               done, pass, timeout, sys_rst_n, code_out, cycles);
    end
  endtask

  task automatic test_timeout();
    max_cycles = 64'd50;
    do_reset();
    step(49);
    checks++;
    if (timeout !== 1'b0 || cycles !== 64'd49) begin
      errors++;
      $display("FAIL pre_timeout: timeout=%b cycles=%0d required 0/49", timeout, cycles);
    end
    step();
    checks++;
    if ({timeout, done, pass} !== 3'b100 || cycles !== 64'd50) begin
      errors++;
      $display("FAIL timeout: timeout=%b done=%b pass=%b cycles=%0d required 1/0/0/50", timeout, done, pass, cycles);
    end
    step(3);
    checks++;
    if (timeout !== 1'b1 || cycles !== 64'd50) begin
      errors++;
      $display("FAIL timeout_frozen: timeout=%b cycles=%0d required 1/50", timeout, cycles);
    end
  endtask

  task automatic test_collision();
    max_cycles = 64'd50;
    do_reset();
    step(49);
    exit_valid = 1'b1; exit_code = 32'hDEAD;
    step();
    exit_valid = 1'b0;
    checks++;
    if ({done, timeout, pass} !== 3'b100 || code_out !== 32'hDEAD || cycles !== 64'd50) begin
      errors++;
      $display("FAIL collision: done=%b timeout=%b pass=%b code=%0h cycles=%0d required 1/0/0/dead/50",
               done, timeout, pass, code_out, cycles);
    end
    max_cycles = '0;
  endtask

  task automatic test_ticks();
    logic exp_tgl;
    div = {16'd0, 16'd3};
    do_reset();
    exp_tgl = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i % 3 == 0) exp_tgl = ~exp_tgl;
      checks++;
      if (tick !== {1'b0, (i % 3 == 0)} || tgl !== {1'b0, exp_tgl}) begin
        errors++;
        $display("FAIL tick_div3_cyc%0d: tick=%b tgl=%b required %b/%b", i, tick, tgl,
                 {1'b0, (i % 3 == 0)}, {1'b0, exp_tgl});
      end
    end
    div = {16'd0, 16'd1};
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_tgl = ~exp_tgl;
      checks++;
      if (tick !== 2'b01 || tgl !== {1'b0, exp_tgl}) begin
        errors++;
        $display("FAIL tick_div1_cyc%0d: tick=%b tgl=%b required 01/%b", i, tick, tgl, {1'b0, exp_tgl});
      end
    end
    div = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    step(14);
    checks++;
    if (s_cycles !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: cycles=%0d required 14", s_cycles);
    end
    step();
    checks++;
    if (s_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat_reach: cycles=%0d required 15", s_cycles);
    end
    step(5);
    checks++;
    if (s_cycles !== 4'd15 || s_timeout !== 1'b0 || s_done !== 1'b0 || s_sys_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cycles=%0d timeout=%b done=%b sys_rst_n=%b required 15/0/0/1",
               s_cycles, s_timeout, s_done, s_sys_rst_n);
    end
  endtask

  task automatic test_mid_reset();
    div = {16'd0, 16'd2};
    do_reset();
    step(11);
    checks++;
    if (tick !== 2'b00 || tgl !== 2'b01 || cycles !== 64'd11) begin
      errors++;
      $display("FAIL mid_pre: tick=%b tgl=%b cycles=%0d required 00/01/11", tick, tgl, cycles);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_rst_n, tick, tgl, cycles, done, pass, timeout, code_out} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear: sys_rst_n=%b tick=%b tgl=%b cycles=%0d, all required 0",
               sys_rst_n, tick, tgl, cycles);
    end
    step(2);
    rst_n = 1'b1;
    for (int i = 1; i <= int'(RST); i++) begin
      step();
      checks++;
      if (sys_rst_n !== (i == int'(RST)) || tick !== 2'b00 || cycles !== 64'd0) begin
        errors++;
        $display("FAIL mid_restretch%0d: sys_rst_n=%b tick=%b cycles=%0d required %b/00/0",
                 i, sys_rst_n, tick, cycles, (i == int'(RST)));
      end
    end
    step(2);
    checks++;
    if (tick !== 2'b01 || tgl !== 2'b01 || cycles !== 64'd2) begin
      errors++;
      $display("FAIL mid_restart: tick=%b tgl=%b cycles=%0d required 01/01/2", tick, tgl, cycles);
    end
    div = '0;
  endtask

  initial begin
    test_reset();
    test_pass_exit();
    test_timeout();
    test_collision();
    test_ticks();
    test_saturation();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
